// File: rtl/multi_channel_tachometer_pkg.sv
// TachPkg: shared speed type and window/scale derivations for the multi-channel tachometer
package TachPkg;
  typedef logic [15:0] rpm_t;
  function automatic int window_cycles(input int refclk_hz, input int window_ms);
    return refclk_hz / 1000 * window_ms;
  endfunction
  function automatic int rpm_scale(input int pulses_per_rev, input int window_ms);
    return 60000 / (pulses_per_rev * window_ms);
  endfunction
  function automatic bit rpm_scale_exact(input int pulses_per_rev, input int window_ms);
    return (60000 % (pulses_per_rev * window_ms)) == 0;
  endfunction
endpackage

// File: rtl/multi_channel_tachometer_filter.sv
// TachChannelFilter: synchronise, debounce and rising-edge detect one tach input
module TachChannelFilter #(
  parameter int FILTER_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic tach,
  output logic rise
);
  localparam int CW = $clog2(FILTER_CYCLES + 1);
  logic s1, s2, level, cand, primed;
  logic [CW-1:0] run, run_next;
  assign run_next = (run != '0 && s2 == cand) ? run + 1'b1 : CW'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      {s1, s2, level, cand, primed, rise} <= '0;
      run <= '0;
    end else begin
      s1 <= tach;
      s2 <= s1;
      rise <= 1'b0;
      if (primed && s2 == level) run <= '0;
      else if (run_next == CW'(FILTER_CYCLES)) begin
        level <= s2;
        primed <= 1'b1;
        run <= '0;
        rise <= primed && s2;
      end else begin
        run <= run_next;
        cand <= s2;
      end
    end
  end
endmodule

// File: rtl/multi_channel_tachometer.sv
// multi_channel_tachometer: per-window fan speed measurement with stall detection and sticky alarms
module multi_channel_tachometer
  import TachPkg::*;
#(
  parameter int NUM_CHANNELS   = 2,
  parameter int REFCLK_HZ      = 250000000,
  parameter int WINDOW_MS      = 1000,
  parameter int PULSES_PER_REV = 2,
  parameter int FILTER_CYCLES  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CHANNELS-1:0]   tach,
  input  logic [NUM_CHANNELS-1:0]   alarm_clr,
  output logic [16*NUM_CHANNELS-1:0] rpm,
  output logic                      rpm_valid,
  output logic [NUM_CHANNELS-1:0]   stall,
  output logic [NUM_CHANNELS-1:0]   stall_alarm
);
  localparam int WINDOW_CYCLES = window_cycles(REFCLK_HZ, WINDOW_MS);
  localparam int RPM_SCALE = rpm_scale(PULSES_PER_REV, WINDOW_MS);
  localparam int WW = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int PW = 16 + $clog2(RPM_SCALE + 1);
  if (!rpm_scale_exact(PULSES_PER_REV, WINDOW_MS)) begin : g_bad_scale
    $error("RPM_SCALE is not an exact integer");
  end
  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 16) begin : g_bad_channels
    $error("NUM_CHANNELS must be within 1..16");
  end
  logic [NUM_CHANNELS-1:0] rise;
  logic [WW-1:0] win_cnt;
  logic wrap;
  assign wrap = win_cnt == WW'(WINDOW_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt <= '0;
      rpm_valid <= 1'b0;
    end else begin
      win_cnt <= wrap ? '0 : win_cnt + 1'b1;
      rpm_valid <= wrap;
    end
  end
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    rpm_t cnt, nxt, rpm_q;
    logic [PW-1:0] prod;
    logic stall_q, alarm_q;
    TachChannelFilter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt (
      .clk  (clk),
      .rst  (rst),
      .tach (tach[i]),
      .rise (rise[i])
    );
    assign nxt = (rise[i] && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
    assign prod = PW'(nxt) * PW'(RPM_SCALE);
    assign rpm[16*i +: 16] = rpm_q;
    assign stall[i] = stall_q;
    assign stall_alarm[i] = alarm_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
        rpm_q <= '0;
        stall_q <= 1'b0;
        alarm_q <= 1'b0;
      end else begin
        cnt <= wrap ? '0 : nxt;
        if (wrap) begin
          rpm_q <= (prod > PW'(16'hFFFF)) ? 16'hFFFF : prod[15:0];
          stall_q <= nxt == '0;
        end
        alarm_q <= (wrap && nxt == '0) || (alarm_q && !alarm_clr[i]);
      end
    end
  end
endmodule

// File: tb/tb_multi_channel_tachometer.sv
// tb_multi_channel_tachometer: randomized window-level checks against a pulse-count reference model
module tb_multi_channel_tachometer;
  localparam int NC = 3;
  localparam int WC = 1000;
  localparam int F = 4;
  localparam int SCALE = 30000;
  logic clk = 1'b0;
  logic rst;
  logic [2:0] tach, alarm_clr;
  logic [47:0] rpm;
  logic rpm_valid;
  logic [2:0] stall, stall_alarm;
  int tests = 0;
  int fails = 0;
  logic [2:0] wave [WC];
  logic [2:0] clr_w [WC];
  int exp_n [NC];
  logic [15:0] m_rpm [NC];
  logic [2:0] m_stall, m_alarm;
  multi_channel_tachometer #(
    .NUM_CHANNELS(3), .REFCLK_HZ(1000000), .WINDOW_MS(1), .PULSES_PER_REV(2), .FILTER_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .tach(tach), .alarm_clr(alarm_clr),
    .rpm(rpm), .rpm_valid(rpm_valid), .stall(stall), .stall_alarm(stall_alarm)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] exp_rpm(input int n);
    return (n * SCALE > 65535) ? 16'hFFFF : 16'(n * SCALE);
  endfunction
  task automatic new_window(input logic [2:0] base);
    for (int k = 0; k < WC; k++) begin
      wave[k] = base;
      clr_w[k] = 3'b000;
    end
    for (int c = 0; c < NC; c++) exp_n[c] = 0;
  endtask
  task automatic add_pulse(input int c, input int start, input int len);
    for (int k = start; k < start + len; k++) wave[k][c] = 1'b1;
    if (len >= F) exp_n[c]++;
  endtask
  task automatic rand_channel(input int c, input int mode);
    int pos, len;
    pos = $urandom_range(10, 80);
    while (pos <= WC - 90) begin
      len = (mode == 1) ? $urandom_range(F, 30) : $urandom_range(1, F - 1);
      add_pulse(c, pos, len);
      pos += len + ((mode == 1) ? $urandom_range(8, 600) : $urandom_range(8, 60));
    end
  endtask
  task automatic do_reset(input string name, input logic held2, input int ncyc);
    int bad_v;
    bad_v = 0;
    rst = 1'b1;
    tach = {held2, 2'b00};
    alarm_clr = 3'b000;
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      if (rpm_valid !== 1'b0) bad_v++;
    end
    tests++;
    if (bad_v != 0) begin
      fails++;
      $display("FAIL %s rpm_valid in reset: %0d cycles high, expected 0", name, bad_v);
    end
    tests++;
    if (rpm !== 48'h0) begin
      fails++;
      $display("FAIL %s rpm after reset: got %h expected 0", name, rpm);
    end
    tests++;
    if (stall !== 3'b000) begin
      fails++;
      $display("FAIL %s stall after reset: got %b expected 000", name, stall);
    end
    tests++;
    if (stall_alarm !== 3'b000) begin
      fails++;
      $display("FAIL %s stall_alarm after reset: got %b expected 000", name, stall_alarm);
    end
    for (int c = 0; c < NC; c++) m_rpm[c] = 16'h0;
    m_stall = 3'b000;
    m_alarm = 3'b000;
    rst = 1'b0;
  endtask
  task automatic run_window(input string name, input int ncyc);
    int bad_v, bad_h, bad_a, first_k;
    logic [47:0] first_rpm;
    bad_v = 0;
    bad_h = 0;
    bad_a = 0;
    first_k = -1;
    first_rpm = '0;
    for (int k = 0; k < ncyc; k++) begin
      tach = wave[k];
      alarm_clr = clr_w[k];
      @(posedge clk);
      #1;
      for (int c = 0; c < NC; c++) begin
        if (k == WC - 1) begin
          m_rpm[c] = exp_rpm(exp_n[c]);
          m_stall[c] = exp_n[c] == 0;
        end
        if (k == WC - 1 && exp_n[c] == 0) m_alarm[c] = 1'b1;
        else if (clr_w[k][c]) m_alarm[c] = 1'b0;
      end
      if (rpm_valid !== (k == WC - 1)) bad_v++;
      if (rpm !== {m_rpm[2], m_rpm[1], m_rpm[0]} || stall !== m_stall) begin
        if (bad_h == 0) begin
          first_k = k;
          first_rpm = rpm;
        end
        bad_h++;
      end
      if (stall_alarm !== m_alarm) bad_a++;
    end
    tests++;
    if (bad_v != 0) begin
      fails++;
      $display("FAIL %s rpm_valid strobe: %0d cycles wrong, expected high only on cycle %0d", name, bad_v, WC);
    end
    tests++;
    if (bad_h != 0) begin
      fails++;
      $display("FAIL %s rpm/stall hold: %0d bad cycles, first k=%0d rpm=%h expected %h", name, bad_h, first_k, first_rpm, {m_rpm[2], m_rpm[1], m_rpm[0]});
    end
    tests++;
    if (bad_a != 0) begin
      fails++;
      $display("FAIL %s stall_alarm tracking: %0d bad cycles, final got %b expected %b", name, bad_a, stall_alarm, m_alarm);
    end
    if (ncyc == WC) begin
      for (int c = 0; c < NC; c++) begin
        tests++;
        if (rpm[16*c +: 16] !== exp_rpm(exp_n[c])) begin
          fails++;
          $display("FAIL %s rpm ch%0d: got %0d expected %0d", name, c, rpm[16*c +: 16], exp_rpm(exp_n[c]));
        end
        tests++;
        if (stall[c] !== (exp_n[c] == 0)) begin
          fails++;
          $display("FAIL %s stall ch%0d: got %b expected %b", name, c, stall[c], exp_n[c] == 0);
        end
      end
    end
  endtask
  task automatic test_reset();
    do_reset("reset", 1'b1, 3);
  endtask
  task automatic test_held_high();
    new_window(3'b100);
    add_pulse(0, 100, 20);
    run_window("held_high", WC);
  endtask
  task automatic test_single_pulse();
    for (int w = 0; w < 2; w++) begin
      new_window(3'b000);
      add_pulse(0, $urandom_range(20, 800), 20);
      run_window("single_pulse", WC);
    end
  endtask
  task automatic test_saturate();
    new_window(3'b000);
    add_pulse(0, 100, 20);
    add_pulse(0, 300, 20);
    add_pulse(0, 500, 20);
    add_pulse(1, 200, 15);
    add_pulse(1, 700, 15);
    add_pulse(2, 400, 25);
    run_window("saturate", WC);
  endtask
  task automatic test_glitch();
    new_window(3'b000);
    for (int s = 25; s < WC - 60; s += 50) add_pulse(1, s, 2);
    add_pulse(0, 400, F);
    add_pulse(2, 300, F - 1);
    run_window("glitch", WC);
  endtask
  task automatic test_alarm_clr();
    new_window(3'b000);
    add_pulse(0, 150, 20);
    clr_w[WC-1][1] = 1'b1;
    run_window("clr_at_update", WC);
    tests++;
    if (stall_alarm[1] !== 1'b1) begin
      fails++;
      $display("FAIL clr_at_update stall_alarm[1]: got %b expected 1", stall_alarm[1]);
    end
    new_window(3'b000);
    add_pulse(0, 150, 20);
    clr_w[500][1] = 1'b1;
    run_window("clr_mid_window", WC);
    new_window(3'b000);
    add_pulse(1, 600, 20);
    clr_w[200][1] = 1'b1;
    clr_w[300][2] = 1'b1;
    run_window("clr_then_spin", WC);
  endtask
  task automatic test_random();
    for (int w = 0; w < 6; w++) begin
      new_window(3'b000);
      for (int c = 0; c < NC; c++) begin
        int mode;
        mode = $urandom_range(0, 2);
        if (mode != 0) rand_channel(c, mode);
        for (int k = 0; k < WC; k++) if ($urandom_range(0, 299) == 0) clr_w[k][c] = 1'b1;
        if ($urandom_range(0, 3) == 0) clr_w[WC-1][c] = 1'b1;
      end
      run_window("random", WC);
    end
  endtask
  task automatic test_reset_mid_window();
    new_window(3'b000);
    add_pulse(0, 100, 20);
    run_window("pre_reset", 500);
    do_reset("mid_reset", 1'b0, 2);
    new_window(3'b000);
    add_pulse(0, 200, 20);
    add_pulse(0, 600, 20);
    run_window("post_reset", WC);
  endtask
  initial begin
    rst = 1'b1;
    tach = 3'b000;
    alarm_clr = 3'b000;
    test_reset();
    test_held_high();
    test_single_pulse();
    test_saturate();
    test_glitch();
    test_alarm_clr();
    test_random();
    test_reset_mid_window();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
